// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and runs the req/gnt/rvalid handshake with instruction memory. Optional macro IF_PERF_CNT_EN adds the perf_fetched/perf_killed counters.
// Latency: IDLE->REQ->WAIT->HOLD, 3 cycles minimum per instruction. Backpressure: the instruction is held stable until dec_ready or a redirect.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                PC_STEP  = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               dec_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_killed
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 kill_q, kill_d;
    logic                 req_q, req_d;
    logic                 valid_q, valid_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
    logic                 fetch_evt;
    logic                 drop_evt;
    logic [ADDR_W-1:0]    redir_tgt;

    // Instructions are halfword aligned, so the target's bit 0 is meaningless.
    assign redir_tgt = redirect_pc & ~ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        fetch_evt  = 1'b0;
        drop_evt   = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect) pc_d = redir_tgt;
                if (imem_gnt) begin
                    state_d = WAIT;
                    // The granted word belongs to the old path when a redirect lands with the grant.
                    kill_d  = redirect;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        drop_evt = 1'b1;
                        kill_d   = 1'b0;
                        state_d  = REQ;
                        if (redirect) pc_d = redir_tgt;
                    end else begin
                        fetch_evt  = 1'b1;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + ADDR_W'(PC_STEP);
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    pc_d   = redir_tgt;
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redir_tgt;
                    state_d = REQ;
                end else if (dec_ready) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = {3'b000, instr_q[INSTR_W-1 -: 3]};

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetched_q, fetched_d;
    logic [15:0] killed_q, killed_d;

    always_comb begin
        fetched_d = fetched_q;
        killed_d  = killed_q;
        if (fetch_evt && (fetched_q != 16'hFFFF)) fetched_d = fetched_q + 16'd1;
        if (drop_evt && (killed_q != 16'hFFFF))   killed_d  = killed_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            killed_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            killed_q  <= killed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_killed  = killed_q;
`else
    logic unused_evt;
    assign unused_evt = fetch_evt ^ drop_evt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized phase checked against a transaction-level model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        dec_ready = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [5:0]  opcode;
    logic [15:0] instr_pc;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_killed;
`endif

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .PC_STEP(2)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
    );

    int total = 0;
    int bad = 0;

    // Memory image, indexed by halfword address.
    logic [15:0] mem [0:32767];

    // Responder knobs: gnt_mode 0 never grants, 1 always grants, 2 grants at random.
    int          gnt_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          outstanding = 0;
    logic [15:0] paddr = 16'h0000;
    int          cnt = 0;

    // Transaction-level expectation: address of the next instruction that should be delivered.
    logic [15:0] exp_next = 16'h0000;
    int          exp_f = 0;
    int          exp_k = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        outstanding = 0;
        exp_next    = 16'h0000;
        exp_f       = 0;
        exp_k       = 0;
    endtask

    // Advance one clock: check the effects of the edge, then drive the memory side for the next edge.
    task automatic cycle();
        logic        po_req, po_valid, a_gnt, a_rv, a_redir, a_dec;
        logic [15:0] po_addr, po_instr, po_pc, a_rpc;
        bit          deliv, was_out;
        po_req = imem_req;  po_valid = instr_valid;  po_addr = imem_addr;
        po_instr = instr;   po_pc = instr_pc;
        a_gnt = imem_gnt;   a_rv = imem_rvalid;  a_redir = redirect;
        a_dec = dec_ready;  a_rpc = redirect_pc;
        @(negedge clk);
        if (a_redir) exp_next = a_rpc & 16'hFFFE;
        was_out = outstanding;
        if (a_rv) outstanding = 0;
        if (po_req === 1'b1 && a_gnt) begin
            chk("grant_while_pending", {31'd0, outstanding}, 0);
            outstanding = 1;
            paddr = po_addr;
            cnt = $urandom_range(lat_max, lat_min);
        end
        deliv = (instr_valid === 1'b1) && (po_valid !== 1'b1);
        if (deliv) begin
            chk("deliv_has_rvalid", {31'd0, a_rv}, 1);
            chk("deliv_pc", {16'd0, instr_pc}, {16'd0, exp_next});
            chk("deliv_instr", {16'd0, instr}, {16'd0, mem[instr_pc[15:1]]});
            chk("deliv_opcode", {26'd0, opcode}, {29'd0, instr[15:13]});
            exp_next = instr_pc + 16'd2;
            if (exp_f < 65535) exp_f++;
        end
        if (a_rv && was_out && !deliv && exp_k < 65535) exp_k++;
        if (po_valid === 1'b1 && !a_dec && !a_redir) begin
            chk("hold_valid", {31'd0, instr_valid}, 1);
            chk("hold_instr", {16'd0, instr}, {16'd0, po_instr});
            chk("hold_pc", {16'd0, instr_pc}, {16'd0, po_pc});
        end
        if (po_req === 1'b1 && !a_gnt && !a_redir) begin
            chk("req_hold", {31'd0, imem_req}, 1);
            chk("addr_hold", {16'd0, imem_addr}, {16'd0, po_addr});
        end
        if (imem_req === 1'b1) chk("req_addr", {16'd0, imem_addr}, {16'd0, exp_next});
        chk("req_while_pending", {31'd0, imem_req & outstanding}, 0);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", {16'd0, perf_fetched}, exp_f);
        chk("perf_killed", {16'd0, perf_killed}, exp_k);
`endif
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        if (outstanding) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem[paddr[15:1]];
            end
        end
        if (imem_req === 1'b1 && !outstanding) begin
            if (gnt_mode == 1) imem_gnt = 1'b1;
            else if (gnt_mode == 2) imem_gnt = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", {31'd0, imem_req}, 0);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_instr", {16'd0, instr}, 0);
        chk("rst_instr_pc", {16'd0, instr_pc}, 0);
        chk("rst_addr", {16'd0, imem_addr}, 0);
        chk("rst_opcode", {26'd0, opcode}, 0);
`ifdef IF_PERF_CNT_EN
        chk("rst_perf_fetched", {16'd0, perf_fetched}, 0);
        chk("rst_perf_killed", {16'd0, perf_killed}, 0);
`endif
    endtask

    initial begin
        bit rprev;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2001;
        mem[1] = 16'h8005;
        mem[2] = 16'hC003;
        model_reset();

        // Reset state.
        cycle();
        cycle();
        chk_reset_outputs();

        // Back-to-back fetch with a 1-cycle memory: valid once every 3 cycles.
        gnt_mode = 1;
        dec_ready = 1'b1;
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) gnt_mode = 0;
            cycle();
            chk("valid_cadence", {31'd0, instr_valid}, (i % 3 == 0) ? 1 : 0);
            if (i == 3) begin
                chk("first_pc", {16'd0, instr_pc}, 16'h0000);
                chk("first_opcode", {26'd0, opcode}, 6'b000001);
            end
            if (i == 6) begin
                chk("second_pc", {16'd0, instr_pc}, 16'h0002);
                chk("second_opcode", {26'd0, opcode}, 6'b000100);
            end
        end

        // No grant for 4 cycles: request and address stay put.
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stall_req", {31'd0, imem_req}, 1);
            chk("stall_addr", {16'd0, imem_addr}, 16'h0004);
            chk("stall_valid", {31'd0, instr_valid}, 0);
        end

        // Redirect while waiting on a slow response: the returning word must be dropped.
        gnt_mode = 1;
        lat_min = 3;
        lat_max = 3;
        cycle();
        cycle();
        chk("in_wait", {31'd0, outstanding}, 1);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        cycle();
        for (int i = 0; i < 8 && outstanding; i++) begin
            cycle();
            chk("dropped_no_valid", {31'd0, instr_valid}, 0);
        end
        chk("drop_done", {31'd0, outstanding}, 0);
        chk("redir_req", {31'd0, imem_req}, 1);
        chk("redir_addr", {16'd0, imem_addr}, 16'h0040);

        // Decode stalls for 5 cycles, then a redirect to an odd target.
        lat_min = 1;
        lat_max = 1;
        dec_ready = 1'b0;
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) cycle();
        chk("stall_fetch_valid", {31'd0, instr_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("dec_stall_pc", {16'd0, instr_pc}, 16'h0040);
            chk("dec_stall_noreq", {31'd0, imem_req}, 0);
        end
        redirect = 1'b1;
        redirect_pc = 16'h0011;
        cycle();
        chk("hold_redir_valid", {31'd0, instr_valid}, 0);
        chk("hold_redir_req", {31'd0, imem_req}, 1);
        chk("hold_redir_addr", {16'd0, imem_addr}, 16'h0010);

        // PC wrap from the top of the address space.
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        dec_ready = 1'b1;
        cycle();
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) cycle();
        chk("wrap_pc", {16'd0, instr_pc}, 16'hFFFE);
        cycle();
        chk("wrap_req", {31'd0, imem_req}, 1);
        chk("wrap_addr", {16'd0, imem_addr}, 16'h0000);

        // Randomized traffic against the model.
        gnt_mode = 2;
        lat_min = 1;
        lat_max = 4;
        rprev = 0;
        for (int i = 0; i < 3000; i++) begin
            dec_ready = ($urandom_range(9, 0) < 6);
            rprev = (!rprev && $urandom_range(19, 0) == 0);
            if (rprev) begin
                redirect = 1'b1;
                redirect_pc = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
            end
            cycle();
        end

        // Reset while a response is pending, then a stray rvalid after release.
        gnt_mode = 1;
        lat_min = 3;
        lat_max = 3;
        dec_ready = 1'b1;
        for (int i = 0; i < 20 && !outstanding; i++) cycle();
        chk("pre_reset_pending", {31'd0, outstanding}, 1);
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        cycle();
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 16'hDEAD;
        cycle();
        chk("late_rv_valid", {31'd0, instr_valid}, 0);
        chk("late_rv_req", {31'd0, imem_req}, 1);
        chk("late_rv_addr", {16'd0, imem_addr}, 16'h0000);
        for (int i = 0; i < 12 && instr_valid !== 1'b1; i++) cycle();
        chk("post_reset_valid", {31'd0, instr_valid}, 1);
        chk("post_reset_instr", {16'd0, instr}, 16'h2001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
